// File: rtl/freq_pkg.sv
// Shared types and defaults for the programmable square-wave generator.
package freq_pkg;

   localparam int unsigned DefCntW   = 13;
   localparam int unsigned DefBurstW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } state_e;

   typedef struct packed {
      logic [DefCntW-1:0]   period;
      logic [DefCntW-1:0]   high;
      logic [DefBurstW-1:0] bursts;
   } cfg_t;

   function automatic logic cfg_legal(input logic [DefCntW-1:0] period,
                                      input logic [DefCntW-1:0] high);
      return (period >= DefCntW'(2)) && (high != '0) && (high < period);
   endfunction

endpackage

// File: rtl/freq_gen_cfg.sv
// Config port: legality check, active and pending config registers.
module freq_gen_cfg
   import freq_pkg::*;
#(
   parameter int unsigned CNT_W   = DefCntW,
   parameter int unsigned BURST_W = DefBurstW
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_high,
   input  logic [BURST_W-1:0] cfg_bursts,
   output logic               cfg_err,
   input  logic               idle,
   input  logic               boundary,
   output logic               applied,
   output logic               act_valid,
   output logic [CNT_W-1:0]   act_period,
   output logic [CNT_W-1:0]   act_high,
   output logic [BURST_W-1:0] act_bursts
);

   cfg_t active_q, active_d;
   cfg_t pend_q, pend_d;
   cfg_t offer;
   logic act_valid_q, act_valid_d;
   logic pend_valid_q, pend_valid_d;
   logic err_q, err_d;
   logic accept, legal;

   assign offer = '{period: DefCntW'(cfg_period),
                    high:   DefCntW'(cfg_high),
                    bursts: DefBurstW'(cfg_bursts)};

   assign cfg_ready = ~pend_valid_q;
   assign accept    = cfg_valid & cfg_ready;
   assign legal     = cfg_legal(offer.period, offer.high);
   // A pending config also drains while idle so it never sits stale after a stop.
   assign applied   = pend_valid_q & (boundary | idle);

   always_comb begin
      active_d     = active_q;
      act_valid_d  = act_valid_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      err_d        = accept & ~legal;
      if (applied) begin
         active_d     = pend_q;
         act_valid_d  = 1'b1;
         pend_valid_d = 1'b0;
      end
      if (accept && legal) begin
         if (idle) begin
            active_d    = offer;
            act_valid_d = 1'b1;
         end else begin
            pend_d       = offer;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         active_q     <= '0;
         act_valid_q  <= 1'b0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         active_q     <= active_d;
         act_valid_q  <= act_valid_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         err_q        <= err_d;
      end
   end

   assign cfg_err    = err_q;
   assign act_valid  = act_valid_q;
   assign act_period = CNT_W'(active_q.period);
   assign act_high   = CNT_W'(active_q.high);
   assign act_bursts = BURST_W'(active_q.bursts);

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator: FSM, phase counter and burst counter.
module freq_gen
   import freq_pkg::*;
#(
   parameter int unsigned CNT_W   = DefCntW,
   parameter int unsigned BURST_W = DefBurstW
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_high,
   input  logic [BURST_W-1:0] cfg_bursts,
   output logic               cfg_err,
   input  logic               start,
   input  logic               stop,
   output logic               out_wave,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] periods_sent
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   phase_q, phase_d;
   logic [BURST_W-1:0] sent_q, sent_d;
   logic [BURST_W-1:0] bcnt_q, bcnt_d;
   logic               stop_q, stop_d;
   logic               out_q, busy_q, done_q;

   logic               idle, last, period_end, boundary, applied;
   logic               act_valid;
   logic [CNT_W-1:0]   act_period, act_high;
   logic [BURST_W-1:0] act_bursts;

   freq_gen_cfg #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
   ) u_cfg (
      .Clock      (Clock),
      .nReset     (nReset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_bursts (cfg_bursts),
      .cfg_err    (cfg_err),
      .idle       (idle),
      .boundary   (boundary),
      .applied    (applied),
      .act_valid  (act_valid),
      .act_period (act_period),
      .act_high   (act_high),
      .act_bursts (act_bursts)
   );

   assign idle       = (state_q == StIdle);
   assign period_end = (state_q == StLow) && (phase_q == act_period);
   // A stop seen in the final LOW cycle itself still ends the run at this period.
   assign last       = stop_q | stop |
                       ((act_bursts != '0) && (bcnt_q + BURST_W'(1) == act_bursts));
   assign boundary   = period_end & ~last;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      sent_d  = sent_q;
      bcnt_d  = bcnt_q;
      stop_d  = stop_q;
      unique case (state_q)
         StIdle: begin
            stop_d = 1'b0;
            if (start && !stop && act_valid) begin
               state_d = StHigh;
               phase_d = CNT_W'(1);
               sent_d  = '0;
               bcnt_d  = '0;
            end
         end
         StHigh: begin
            if (stop) stop_d = 1'b1;
            if (phase_q == act_high) state_d = StLow;
            phase_d = phase_q + CNT_W'(1);
         end
         StLow: begin
            if (stop) stop_d = 1'b1;
            if (period_end) begin
               sent_d = sent_q + BURST_W'(1);
               if (last) begin
                  state_d = StIdle;
                  phase_d = '0;
               end else begin
                  state_d = StHigh;
                  phase_d = CNT_W'(1);
                  bcnt_d  = applied ? '0 : bcnt_q + BURST_W'(1);
               end
            end else begin
               phase_d = phase_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q <= StIdle;
         phase_q <= '0;
         sent_q  <= '0;
         bcnt_q  <= '0;
         stop_q  <= 1'b0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         sent_q  <= sent_d;
         bcnt_q  <= bcnt_d;
         stop_q  <= stop_d;
         out_q   <= (state_d == StHigh);
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_q == StLow) && (state_d == StIdle);
      end
   end

   assign out_wave     = out_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign periods_sent = sent_q;

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
Programmable square-wave generator. Synthesised on the Cyclone IV tester FPGA alongside the frequency counter. Drives a known-period stimulus onto a Superchip input, or loops back into the counter for calibration. Period and high time are set in Clock cycles through a valid/ready config port; output runs continuously or for a fixed burst of periods.

Parameters:
CNT_W, 13, width of period/high-time fields (matches counter's cycle-count width)
BURST_W, 8, width of burst-length field and periods-sent counter

Ports:
Clock  in  1  system clock
nReset  in  1  synchronous active-low reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_period  in  CNT_W  period in Clock cycles, legal range 2..2^CNT_W-1
cfg_high  in  CNT_W  high time in cycles, legal range 1..cfg_period-1
cfg_bursts  in  BURST_W  periods to emit; 0 = continuous
cfg_err  out  1  one-cycle pulse: offered config illegal, discarded
start  in  1  begin generation (level sampled each cycle)
stop  in  1  graceful stop request
out_wave  out  1  registered square wave, glitch-free
busy  out  1  high from first HIGH cycle until return to IDLE
done  out  1  one-cycle pulse on return to IDLE
periods_sent  out  BURST_W  completed periods since last start; wraps mod 2^BURST_W

Behaviour:
- Clock and reset: all state on posedge Clock. nReset=0 at an edge forces reset values.
- Reset values: out_wave=0, busy=0, done=0, cfg_ready=1, cfg_err=0, periods_sent=0, FSM=IDLE, active config invalid, no pending config.
- Reset mid-operation: out_wave drops to 0 at the reset edge; no done pulse.
- Config handshake: accepted when cfg_valid & cfg_ready at an edge.
  - Illegal config (period<2, high=0, high>=period): cfg_err=1 next cycle; nothing stored.
  - Legal config in IDLE: written directly to active config.
  - Legal config while busy: written to pending; cfg_ready=0 until pending is applied.
  - Pending is applied at the next period boundary (LOW→HIGH transition), then cfg_ready=1 again.
  - A new burst count loaded mid-run restarts burst counting from that boundary.
- FSM states:
  - IDLE: out_wave=0, busy=0.
  - HIGH: out_wave=1.
  - LOW: out_wave=0.
- Phase counter: CNT_W bits, counts 1..period within a period.
- IDLE→HIGH: start=1 & stop=0 & active config valid. First HIGH cycle is the cycle after start is sampled.
  - start with no valid config: ignored.
  - start & stop together in IDLE: stop wins, start ignored.
- HIGH→LOW: after cfg_high HIGH cycles.
- LOW→HIGH: after period-high LOW cycles, when the period is not the last. periods_sent increments at this boundary.
- LOW→IDLE: at end of the final LOW cycle when:
  - stop has been latched, or
  - periods_sent+1 == bursts (bursts≠0).
  - On this exit: periods_sent increments, done=1 and busy=0 in the first IDLE cycle.
- stop while busy: latched; current period always completes, so no runt pulse. stop in IDLE: no effect.
- start while busy: ignored.
- periods_sent clears to 0 on the IDLE→HIGH transition.
- Continuous mode (bursts=0): runs until stop.

Decomposition:
- Package freq_pkg:
  - CNT_W and BURST_W defaults.
  - State enum typedef {IDLE, HIGH, LOW}.
  - Packed struct for config {period, high, bursts}.
- One sub-module, freq_gen_cfg: legality check, active/pending registers, cfg_ready/cfg_err. The top module holds the FSM, phase counter and burst counter.

Test Plan:
- Reset then start with no config → out_wave stays 0, busy=0, no done for 20 cycles.
- Load P=8,H=3,bursts=3; start at cycle 0:
  - out_wave high in cycles 1-3, 9-11, 17-19; low otherwise.
  - done and busy=0 at cycle 25; periods_sent=3.
- Illegal offers (P=5,H=5), (P=1,H=1), (P=6,H=0) → cfg_err pulse each, cfg_ready stays 1, later run uses prior config.
- Continuous P=10,H=5; load P=4,H=1 at cycle 13:
  - cfg_ready=0 from cycle 14 until boundary at cycle 21.
  - From cycle 21 pattern becomes 1 high / 3 low.
  - stop at cycle 22 → final LOW ends at cycle 24, done at cycle 25.
- Start and stop asserted same cycle in IDLE → no output. Reset asserted during HIGH → out_wave 0 next edge, no done.
- Loopback into frequency counter, P=100, H=50, continuous → out_freq settles at 100 ±1 after 10 periods.
